// File: rtl/inter_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// inter_tx_scheduler_if
//   Bundle of the requester, link and status signals of inter_tx_scheduler.
//
//   master : the environment (two requesters, the interboard link, a monitor)
//   slave  : the scheduler itself
//
//   interboard_rst            synchronous flush requested by the remote board
//   req0_valid/_msg_type/_number, req0_ready   requester 0 (game FSM)
//   req1_valid/_msg_type/_number, req1_ready   requester 1 (keyboard/echo path)
//   inter_ready               interboard link idle
//   transmit, ctrl_en         single-cycle launch strobes to the link
//   ctrl_msg_type/ctrl_number message presented to the link
//   busy, fifo_count, error   status
// -----------------------------------------------------------------------------
interface inter_tx_scheduler_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          interboard_rst;
  logic          req0_valid;
  logic [2:0]    req0_msg_type;
  logic [4:0]    req0_number;
  logic          req0_ready;
  logic          req1_valid;
  logic [2:0]    req1_msg_type;
  logic [4:0]    req1_number;
  logic          req1_ready;
  logic          inter_ready;
  logic          transmit;
  logic          ctrl_en;
  logic [2:0]    ctrl_msg_type;
  logic [4:0]    ctrl_number;
  logic          busy;
  logic [CW-1:0] fifo_count;
  logic          error;

  modport master (
    output interboard_rst,
    output req0_valid, req0_msg_type, req0_number,
    input  req0_ready,
    output req1_valid, req1_msg_type, req1_number,
    input  req1_ready,
    output inter_ready,
    input  transmit, ctrl_en, ctrl_msg_type, ctrl_number,
    input  busy, fifo_count, error
  );

  modport slave (
    input  interboard_rst,
    input  req0_valid, req0_msg_type, req0_number,
    output req0_ready,
    input  req1_valid, req1_msg_type, req1_number,
    output req1_ready,
    input  inter_ready,
    output transmit, ctrl_en, ctrl_msg_type, ctrl_number,
    output busy, fifo_count, error
  );
endinterface

// File: rtl/inter_tx_scheduler.sv
// -----------------------------------------------------------------------------
// inter_tx_scheduler
//   Merges messages from two requesters through a round-robin arbiter into a
//   small FIFO, then issues them one at a time to the interboard link using a
//   launch / link-busy / link-idle handshake.
//
// Ports
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   inter_tx_scheduler_if.slave (requesters, link, status; see the
//         interface file for the signal list)
//
// Parameters
//   DEPTH           FIFO depth, power of 2 in 2..16
//   TIMEOUT_CYCLES  cycles waited on the link per attempt (timeout build)
//   MAX_RETRY       resends after the first timeout (timeout build)
//
// Build option
//   TX_TIMEOUT_EN   when defined, each attempt is bounded by TIMEOUT_CYCLES;
//                   after MAX_RETRY resends the head is dropped and the sticky
//                   error flag is set. When undefined, the FSM waits on the
//                   link indefinitely and error is constant 0.
// -----------------------------------------------------------------------------
module inter_tx_scheduler #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRY      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  inter_tx_scheduler_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_BUSY,
    ST_WAIT_DONE
  } state_t;

  state_t        r_state;
  state_t        w_state_next;

  // message storage; head is captured into r_ctrl_* when a launch starts
  logic [2:0]    r_fifo_type [DEPTH];
  logic [4:0]    r_fifo_num  [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // 0: requester 0 wins a tie, 1: requester 1 wins a tie
  logic          r_rr_ptr;

  logic [2:0]    r_ctrl_type;
  logic [4:0]    r_ctrl_num;

  logic          w_full;
  logic          w_empty;
  logic          w_accept_ok;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_push;
  logic          w_pop;
  logic          w_load_ctrl;
  logic [2:0]    w_push_type;
  logic [4:0]    w_push_num;

  // ---------------------------------------------------------------------------
  // Arbiter
  // ---------------------------------------------------------------------------
  // Fullness is judged on the registered count only, so a pop in the same
  // cycle never opens a slot early. The flush and the async reset also close
  // the gate so nothing is accepted while state is being discarded.
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_accept_ok = !w_full && !bus.interboard_rst && rst;

  assign w_grant0 = w_accept_ok && bus.req0_valid && (!bus.req1_valid || !r_rr_ptr);
  assign w_grant1 = w_accept_ok && bus.req1_valid && (!bus.req0_valid ||  r_rr_ptr);
  assign w_push   = w_grant0 || w_grant1;

  assign w_push_type = w_grant0 ? bus.req0_msg_type : bus.req1_msg_type;
  assign w_push_num  = w_grant0 ? bus.req0_number   : bus.req1_number;

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;

  // ---------------------------------------------------------------------------
  // Optional per-attempt timeout
  // ---------------------------------------------------------------------------
`ifdef TX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 2);
  localparam int RW = $clog2(MAX_RETRY + 2);

  logic [TW-1:0] r_tmo_cnt;
  logic [RW-1:0] r_retry;
  logic          r_error;
  logic          w_tmo_hit;
  logic          w_resend;
  logic          w_drop;
  logic          w_in_wait;
  logic          w_next_wait;

  assign w_tmo_hit   = (r_tmo_cnt == TW'(TIMEOUT_CYCLES));
  assign w_in_wait   = (r_state == ST_WAIT_BUSY) || (r_state == ST_WAIT_DONE);
  assign w_next_wait = (w_state_next == ST_WAIT_BUSY) || (w_state_next == ST_WAIT_DONE);
`endif

  // ---------------------------------------------------------------------------
  // Issue FSM, next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_load_ctrl  = 1'b0;
`ifdef TX_TIMEOUT_EN
    w_resend     = 1'b0;
    w_drop       = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && bus.inter_ready) begin
          w_state_next = ST_SEND;
          w_load_ctrl  = 1'b1;
        end
      end
      ST_SEND: begin
        w_state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        // the link signals that it took the message by dropping inter_ready
        if (!bus.inter_ready) begin
          w_state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.inter_ready) begin
          w_state_next = ST_IDLE;
          w_pop        = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
`ifdef TX_TIMEOUT_EN
    // A timeout only applies while the FSM would otherwise keep waiting;
    // a real link handshake in the same cycle takes precedence.
    if (w_in_wait && (w_state_next == r_state) && w_tmo_hit) begin
      if (r_retry < RW'(MAX_RETRY)) begin
        w_state_next = ST_SEND;
        w_resend     = 1'b1;
      end else begin
        w_state_next = ST_IDLE;
        w_pop        = 1'b1;
        w_drop       = 1'b1;
      end
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // State, pointers, count, arbiter pointer, link outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_rr_ptr    <= 1'b0;
      r_ctrl_type <= '0;
      r_ctrl_num  <= '0;
    end else if (bus.interboard_rst) begin
      // flush: queued and in-flight messages are discarded; the last
      // presented message stays on ctrl_* like after a normal pop
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr_ptr <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
        r_rr_ptr <= w_grant0;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_load_ctrl) begin
        r_ctrl_type <= r_fifo_type[r_rd_ptr];
        r_ctrl_num  <= r_fifo_num[r_rd_ptr];
      end
    end
  end

  // storage needs no reset: an entry is only read after it has been written
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_type[r_wr_ptr] <= w_push_type;
      r_fifo_num[r_wr_ptr]  <= w_push_num;
    end
  end

`ifdef TX_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
      r_retry   <= '0;
      r_error   <= 1'b0;
    end else if (bus.interboard_rst) begin
      r_tmo_cnt <= '0;
      r_retry   <= '0;
      r_error   <= 1'b0;
    end else begin
      // counts cycles of the current attempt; restarts on every (re)launch
      if (w_in_wait && w_next_wait) begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end else begin
        r_tmo_cnt <= '0;
      end
      if (w_resend) begin
        r_retry <= r_retry + RW'(1);
      end else if (w_pop) begin
        r_retry <= '0;
      end
      if (w_drop) begin
        r_error <= 1'b1;
      end
    end
  end

  assign bus.error = r_error;
`else
  assign bus.error = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.transmit      = (r_state == ST_SEND);
  assign bus.ctrl_en       = (r_state == ST_SEND);
  assign bus.ctrl_msg_type = r_ctrl_type;
  assign bus.ctrl_number   = r_ctrl_num;
  assign bus.busy          = (r_state != ST_IDLE) || !w_empty;
  assign bus.fifo_count    = r_count;

endmodule

// File: tb/tb_inter_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_inter_tx_scheduler
//   Directed bench for inter_tx_scheduler (DEPTH=4, TIMEOUT_CYCLES=16,
//   MAX_RETRY=2). Arbiter/FIFO behaviour is driven from a vector table;
//   launch latency, link handshake, flush, async reset and the optional
//   timeout are hand-written sequences.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_inter_tx_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  inter_tx_scheduler_if #(.DEPTH(4)) bus ();

  inter_tx_scheduler #(
    .DEPTH          (4),
    .TIMEOUT_CYCLES (16),
    .MAX_RETRY      (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       v0;
    logic [2:0] t0;
    logic [4:0] n0;
    logic       v1;
    logic [2:0] t1;
    logic [4:0] n1;
    logic       er0;
    logic       er1;
    int         ecount;
  } vec_t;

  vec_t       vecs [7];
  logic [7:0] exp_q [$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // outputs are sampled 1ns after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid    = 1'b0;
    bus.req0_msg_type = '0;
    bus.req0_number   = '0;
    bus.req1_valid    = 1'b0;
    bus.req1_msg_type = '0;
    bus.req1_number   = '0;
  endtask

  // wait for a launch, check the presented message, then play the link:
  // busy for one cycle, idle again -> head is popped
  task automatic serve_one(input logic [2:0] et, input logic [4:0] en, input string nm);
    int waited;
    waited = 0;
    bus.inter_ready = 1'b1;
    while (bus.transmit !== 1'b1 && waited < 50) begin
      tick();
      waited++;
    end
    check({nm, "_transmit"}, bus.transmit, 1);
    check({nm, "_ctrl_en"},  bus.ctrl_en, 1);
    check({nm, "_type"},     bus.ctrl_msg_type, et);
    check({nm, "_number"},   bus.ctrl_number, en);
    $display("serve %s: type=%0d number=%0d after %0d cycles", nm, bus.ctrl_msg_type, bus.ctrl_number, waited);
    tick();
    check({nm, "_pulse_end"}, bus.transmit, 0);
    bus.inter_ready = 1'b0;
    tick();
    bus.inter_ready = 1'b1;
    tick();
  endtask

  task automatic count_transmits(input int cycles, output int seen);
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      if (bus.transmit === 1'b1) seen++;
      tick();
    end
  endtask

  task automatic flush_pulse();
    bus.interboard_rst = 1'b1;
    tick();
    bus.interboard_rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         seen;
    logic [7:0] e;

    vecs[0] = '{1'b1, 3'd1, 5'd1,  1'b1, 3'd2, 5'd2,  1'b1, 1'b0, 1};
    vecs[1] = '{1'b0, 3'd0, 5'd0,  1'b0, 3'd0, 5'd0,  1'b0, 1'b0, 1};
    vecs[2] = '{1'b1, 3'd3, 5'd3,  1'b0, 3'd0, 5'd0,  1'b1, 1'b0, 2};
    vecs[3] = '{1'b0, 3'd0, 5'd0,  1'b1, 3'd4, 5'd4,  1'b0, 1'b1, 3};
    vecs[4] = '{1'b1, 3'd5, 5'd5,  1'b1, 3'd6, 5'd6,  1'b1, 1'b0, 4};
    vecs[5] = '{1'b1, 3'd7, 5'd7,  1'b1, 3'd1, 5'd8,  1'b0, 1'b0, 4};
    vecs[6] = '{1'b0, 3'd0, 5'd0,  1'b1, 3'd2, 5'd9,  1'b0, 1'b0, 4};

    // ---------------- reset state ----------------
    idle_inputs();
    bus.interboard_rst = 1'b0;
    bus.inter_ready    = 1'b1;
    bus.req0_valid     = 1'b1;
    tick();
    tick();
    check("rst_req0_ready", bus.req0_ready, 0);
    check("rst_transmit",   bus.transmit, 0);
    check("rst_busy",       bus.busy, 0);
    check("rst_count",      bus.fifo_count, 0);
    check("rst_error",      bus.error, 0);
    check("rst_ctrl_type",  bus.ctrl_msg_type, 0);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    tick();

    // ---------------- single message, launch latency ----------------
    bus.req0_valid    = 1'b1;
    bus.req0_msg_type = 3'd2;
    bus.req0_number   = 5'd17;
    #1;
    check("lat_ready0", bus.req0_ready, 1);
    tick();
    idle_inputs();
    check("lat_count1",    bus.fifo_count, 1);
    check("lat_tx_early",  bus.transmit, 0);
    tick();
    check("lat_transmit",  bus.transmit, 1);
    check("lat_ctrl_en",   bus.ctrl_en, 1);
    check("lat_type",      bus.ctrl_msg_type, 2);
    check("lat_number",    bus.ctrl_number, 17);
    tick();
    check("lat_pulse_end", bus.transmit, 0);
    bus.inter_ready = 1'b0;
    tick();
    check("lat_count_wait", bus.fifo_count, 1);
    bus.inter_ready = 1'b1;
    tick();
    check("lat_count0",    bus.fifo_count, 0);
    check("lat_busy0",     bus.busy, 0);
    check("lat_hold_num",  bus.ctrl_number, 17);
    $display("txn single: type=2 number=17 launched and popped");

    // ---------------- flush resets arbiter pointer (was on req1) --------
    bus.inter_ready    = 1'b0;
    bus.interboard_rst = 1'b1;
    bus.req0_valid     = 1'b1;
    #1;
    check("flush_ready0", bus.req0_ready, 0);
    tick();
    bus.interboard_rst = 1'b0;
    idle_inputs();

    // ---------------- vector table: arbiter and FIFO fill ----------------
    for (int i = 0; i < 7; i++) begin
      bus.req0_valid    = vecs[i].v0;
      bus.req0_msg_type = vecs[i].t0;
      bus.req0_number   = vecs[i].n0;
      bus.req1_valid    = vecs[i].v1;
      bus.req1_msg_type = vecs[i].t1;
      bus.req1_number   = vecs[i].n1;
      #1;
      check($sformatf("vec%0d_ready0", i), bus.req0_ready, vecs[i].er0);
      check($sformatf("vec%0d_ready1", i), bus.req1_ready, vecs[i].er1);
      if (vecs[i].er0) exp_q.push_back({vecs[i].t0, vecs[i].n0});
      if (vecs[i].er1) exp_q.push_back({vecs[i].t1, vecs[i].n1});
      tick();
      check($sformatf("vec%0d_count", i), bus.fifo_count, vecs[i].ecount);
      $display("vec %0d: v0=%0d v1=%0d ready0=%0d ready1=%0d count=%0d",
               i, vecs[i].v0, vecs[i].v1, vecs[i].er0, vecs[i].er1, bus.fifo_count);
    end
    idle_inputs();

    // ---------------- link held busy: nothing launches ----------------
    count_transmits(6, seen);
    check("hold_no_transmit", seen, 0);
    check("hold_busy", bus.busy, 1);

    // ---------------- drain in acceptance order ----------------
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      serve_one(e[7:5], e[4:0], $sformatf("drain%0d", i));
    end
    check("drain_count", bus.fifo_count, 0);

    // ---------------- both requesters for 4 cycles, then full ----------
    bus.inter_ready = 1'b0;
    flush_pulse();
    for (int i = 0; i < 4; i++) begin
      bus.req0_valid    = 1'b1;
      bus.req0_msg_type = 3'(i);
      bus.req0_number   = 5'(10 + i);
      bus.req1_valid    = 1'b1;
      bus.req1_msg_type = 3'(4 + i);
      bus.req1_number   = 5'(20 + i);
      #1;
      check($sformatf("rr%0d_ready0", i), bus.req0_ready, (i % 2 == 0) ? 1 : 0);
      check($sformatf("rr%0d_ready1", i), bus.req1_ready, (i % 2 == 1) ? 1 : 0);
      tick();
      $display("rr %0d: accepted requester %0d count=%0d", i, i % 2, bus.fifo_count);
    end
    check("rr_full_count", bus.fifo_count, 4);
    #1;
    check("rr_full_ready0", bus.req0_ready, 0);
    check("rr_full_ready1", bus.req1_ready, 0);
    idle_inputs();

    // ---------------- flush while waiting on link with 3 queued ----------
    serve_one(3'd0, 5'd10, "first_rr");
    check("pre_flush_count3", bus.fifo_count, 3);
    seen = 0;
    while (bus.transmit !== 1'b1 && seen < 20) begin
      tick();
      seen++;
    end
    check("pre_flush_launch", bus.transmit, 1);
    tick();
    bus.inter_ready = 1'b0;
    tick();
    check("wait_done_count", bus.fifo_count, 3);
    flush_pulse();
    check("flush_count", bus.fifo_count, 0);
    check("flush_busy",  bus.busy, 0);
    bus.inter_ready = 1'b1;
    count_transmits(10, seen);
    check("flush_no_transmit", seen, 0);
    $display("txn flush: queue emptied during link wait");

    // ---------------- async reset one cycle after SEND ----------------
    bus.req0_valid    = 1'b1;
    bus.req0_msg_type = 3'd5;
    bus.req0_number   = 5'd9;
    tick();
    idle_inputs();
    seen = 0;
    while (bus.transmit !== 1'b1 && seen < 20) begin
      tick();
      seen++;
    end
    check("mid_launch", bus.transmit, 1);
    tick();
    rst = 1'b0;
    #1;
    check("mid_rst_transmit", bus.transmit, 0);
    check("mid_rst_ctrl_en",  bus.ctrl_en, 0);
    check("mid_rst_type",     bus.ctrl_msg_type, 0);
    check("mid_rst_number",   bus.ctrl_number, 0);
    check("mid_rst_count",    bus.fifo_count, 0);
    check("mid_rst_busy",     bus.busy, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    count_transmits(10, seen);
    check("mid_rst_no_retransmit", seen, 0);
    $display("txn reset: in-flight message discarded");

`ifdef TX_TIMEOUT_EN
    // ---------------- timeout: link never takes the message ----------------
    begin
      int         stamps [4];
      logic [2:0] types  [4];
      int         np;
      np = 0;
      bus.inter_ready   = 1'b1;
      bus.req0_valid    = 1'b1;
      bus.req0_msg_type = 3'd1;
      bus.req0_number   = 5'd3;
      tick();
      bus.req0_msg_type = 3'd6;
      bus.req0_number   = 5'd20;
      tick();
      idle_inputs();
      for (int c = 0; c < 120 && np < 4; c++) begin
        if (bus.transmit === 1'b1) begin
          stamps[np] = c;
          types[np]  = bus.ctrl_msg_type;
          $display("timeout pulse %0d at cycle %0d type=%0d", np, c, bus.ctrl_msg_type);
          np++;
        end
        tick();
      end
      check("tmo_pulses", np, 4);
      if (np == 4) begin
        check("tmo_gap1", stamps[1] - stamps[0], 18);
        check("tmo_gap2", stamps[2] - stamps[1], 18);
        check("tmo_gap3", stamps[3] - stamps[2], 19);
        check("tmo_type0", types[0], 1);
        check("tmo_type2", types[2], 1);
        check("tmo_next_type", types[3], 6);
      end
      check("tmo_error", bus.error, 1);
      check("tmo_count", bus.fifo_count, 1);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inter_tx_scheduler.md
INTER_TX_SCHEDULER -- requirements
Module: inter_tx_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4, message FIFO depth (power of 2, 2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000000, max cycles waiting on link per attempt.
REQ-003 SHALL have parameter MAX_RETRY, default 3, resend attempts after first timeout.
REQ-004 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port interboard_rst  in  1  synchronous flush requested by remote board.
REQ-007 SHALL have port req0_valid/req0_msg_type/req0_number  in  1/3/5  requester 0 (game FSM) message.
REQ-008 SHALL have port req0_ready  out  1  requester 0 accepted when valid&ready in same cycle.
REQ-009 SHALL have port req1_valid/req1_msg_type/req1_number/req1_ready, identical to requester 0 for requester 1 (keyboard/echo path).
REQ-010 SHALL have port inter_ready  in  1  interboard link idle.
REQ-011 SHALL have port transmit, ctrl_en  out  1 each  single-cycle launch strobes to link.
REQ-012 SHALL have port ctrl_msg_type, ctrl_number  out  3, 5  message presented to link.
REQ-013 SHALL have port busy  out  1  high when FSM not IDLE or FIFO non-empty.
REQ-014 SHALL have port fifo_count  out  $clog2(DEPTH)+1  entries queued.
REQ-015 SHALL have port error  out  1  sticky drop indicator.

Function
REQ-016 Arbiter SHALL enqueue at most one message per cycle, only when registered fifo_count < DEPTH.
REQ-017 With one valid requester, that requester SHALL get ready; with both valid, round-robin pointer SHALL pick, pointer SHALL toggle to the other requester after each grant; non-granted ready SHALL be 0.
REQ-018 When FIFO full, both readys SHALL be 0 even if a pop occurs in the same cycle.
REQ-019 FIFO SHALL preserve acceptance order; read/write pointers wrap modulo DEPTH.
REQ-020 Issue FSM states: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE->SEND when FIFO non-empty and inter_ready=1; SEND SHALL drive transmit=ctrl_en=1 for exactly one cycle with FIFO head on ctrl_msg_type/ctrl_number.
REQ-022 SEND->WAIT_BUSY unconditionally; WAIT_BUSY->WAIT_DONE when inter_ready=0; WAIT_DONE->IDLE when inter_ready=1, popping head on that transition.
REQ-023 ctrl_msg_type/ctrl_number SHALL hold stable from SEND until pop, then hold last value.
REQ-024 Latency: message accepted at edge N into empty FIFO with inter_ready=1 SHALL see transmit high in cycle N+2.
REQ-025 Enqueue and pop in same cycle SHALL leave fifo_count unchanged.
REQ-026 interboard_rst=1 SHALL, at next edge, empty FIFO, force IDLE, zero strobes, reset pointer to requester 0, clear error and retry counter; readys SHALL be 0 that cycle.

Reset
REQ-027 rst=0 SHALL asynchronously clear FIFO, FSM to IDLE, pointer to requester 0, counters, and all outputs to 0.
REQ-028 Reset mid-transfer SHALL discard the in-flight message without transmit re-assertion after release.

Configuration
REQ-029 With TX_TIMEOUT_EN defined, a per-attempt counter SHALL run in WAIT_BUSY/WAIT_DONE; at TIMEOUT_CYCLES it SHALL return to SEND (resend same head) if retries < MAX_RETRY, else pop head, set error=1, go IDLE.
REQ-030 Without TX_TIMEOUT_EN, FSM SHALL wait indefinitely, no counter logic exists, error SHALL be tied 0.

Verification
REQ-031 Reset then req0 (type 3'd2, number 5'd17) with inter_ready=1 -> transmit/ctrl_en one-cycle pulse at accept+2, outputs 2/17, fifo_count 1->0 after link handshake.
REQ-032 Both requesters valid 4 consecutive cycles, DEPTH=4 -> accepted order req0,req1,req0,req1; fifo_count=4; readys 0 while full.
REQ-033 inter_ready held 0 with 2 entries queued -> no transmit; raise inter_ready -> entries issued in FIFO order, one per link handshake.
REQ-034 interboard_rst pulse while in WAIT_DONE with 3 queued -> next cycle fifo_count=0, busy=0, no further transmit.
REQ-035 TX_TIMEOUT_EN, TIMEOUT_CYCLES=16, MAX_RETRY=2, link never drops inter_ready -> 3 transmit pulses 18 cycles apart, then error=1, head dropped, next entry issued.
REQ-036 rst=0 asserted one cycle after SEND -> all outputs 0 immediately; after release, no transmit with empty FIFO.
